// File: rtl/rt_timer_ctrl.sv
// rt_timer_ctrl: CSR-side sequencer for the 64-bit real-time counter.
// Combines two 32-bit MTIME writes into one atomic counter load, derives the
// counter enable from a programmable prescaler, holds MTIMECMP and raises
// the machine timer interrupt. LO reads snapshot the matching HI word.
module rt_timer_ctrl #(
    parameter int COUNT_LEN = 64,
    parameter int PRESC_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [2:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 rd_en,
    input  logic [2:0]           rd_addr,
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    input  logic [COUNT_LEN-1:0] cnt_value,
    output logic                 cnt_load,
    output logic [COUNT_LEN-1:0] cnt_data,
    output logic                 cnt_en,
    output logic                 timer_irq
);

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;

    typedef enum logic [1:0] {IDLE, LO_STAGED, LOAD} state_t;

    state_t               state, state_nxt;
    logic [31:0]          lo_stage, lo_stage_nxt;
    logic [COUNT_LEN-1:0] cnt_data_nxt;

    logic                 run, irq_en;
    logic [PRESC_W-1:0]   presc, presc_cnt;
    logic [COUNT_LEN-1:0] cmp;
    logic                 cmp_lock;
    logic [31:0]          hi_snap;
    logic                 snap_valid;
    logic                 snap_is_cmp;   // snapshot belongs to MTIMECMP pair
    logic                 presc_chg;

    assign cnt_load  = (state == LOAD);
    // The load cycle suppresses the enable so the counter sees only the load.
    assign cnt_en    = run && (presc_cnt == presc) && (state != LOAD);
    assign presc_chg = wr_en && (wr_addr == A_CTRL) && (wr_data[15:8] != presc);

    // MTIME write sequencing state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lo_stage <= '0;
            cnt_data <= '0;
        end else begin
            state    <= state_nxt;
            lo_stage <= lo_stage_nxt;
            cnt_data <= cnt_data_nxt;
        end
    end

    // MTIME next state: LOAD behaves like IDLE for a write arriving in it,
    // so back-to-back HI writes give back-to-back load pulses.
    always_comb begin
        state_nxt    = (state == LOAD) ? IDLE : state;
        lo_stage_nxt = lo_stage;
        cnt_data_nxt = cnt_data;
        if (wr_en) begin
            case (wr_addr)
                A_MTIME_LO: begin
                    state_nxt    = LO_STAGED;
                    lo_stage_nxt = wr_data;
                end
                A_MTIME_HI: begin
                    state_nxt    = LOAD;
                    cnt_data_nxt = {wr_data,
                                    (state == LO_STAGED) ? lo_stage : cnt_value[31:0]};
                end
                default: ;
            endcase
        end
    end

    // Prescaler: counts 0..presc while running, restarts on load or divisor change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc_cnt <= '0;
        else if (state == LOAD || presc_chg)
            presc_cnt <= '0;
        else if (run)
            presc_cnt <= (presc_cnt == presc) ? '0 : presc_cnt + PRESC_W'(1);
    end

    // CTRL and MTIMECMP registers; LO write locks the interrupt until HI lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= 1'b0;
            irq_en   <= 1'b0;
            presc    <= '0;
            cmp      <= '1;
            cmp_lock <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                A_CMP_LO: begin
                    cmp[31:0] <= wr_data;
                    cmp_lock  <= 1'b1;
                end
                A_CMP_HI: begin
                    cmp[63:32] <= wr_data;
                    cmp_lock   <= 1'b0;
                end
                A_CTRL: begin
                    run    <= wr_data[0];
                    irq_en <= wr_data[1];
                    presc  <= wr_data[15:8];
                end
                default: ;
            endcase
        end
    end

    // Timer interrupt, registered unsigned 64-bit compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer_irq <= 1'b0;
        else
            timer_irq <= irq_en && !cmp_lock && (cnt_value >= cmp);
    end

    // CSR read port with LO-read snapshot of the matching HI word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            hi_snap     <= '0;
            snap_valid  <= 1'b0;
            snap_is_cmp <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                case (rd_addr)
                    A_MTIME_LO: begin
                        rd_data     <= cnt_value[31:0];
                        hi_snap     <= cnt_value[63:32];
                        snap_valid  <= 1'b1;
                        snap_is_cmp <= 1'b0;
                    end
                    A_CMP_LO: begin
                        rd_data     <= cmp[31:0];
                        hi_snap     <= cmp[63:32];
                        snap_valid  <= 1'b1;
                        snap_is_cmp <= 1'b1;
                    end
                    // Any HI read consumes or invalidates the snapshot.
                    A_MTIME_HI: begin
                        rd_data    <= (snap_valid && !snap_is_cmp) ? hi_snap
                                                                   : cnt_value[63:32];
                        snap_valid <= 1'b0;
                    end
                    A_CMP_HI: begin
                        rd_data    <= (snap_valid && snap_is_cmp) ? hi_snap : cmp[63:32];
                        snap_valid <= 1'b0;
                    end
                    A_CTRL:  rd_data <= {16'b0, presc, 6'b0, irq_en, run};
                    default: rd_data <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rt_timer_ctrl.sv
// Bench for rt_timer_ctrl: directed scenarios followed by random CSR traffic,
// every cycle checked against a transaction-level model of the register file,
// prescaler and an ideal 64-bit counter driven from the model's own outputs.
module tb_rt_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [63:0] cnt_value = '0;
    logic        cnt_load;
    logic [63:0] cnt_data;
    logic        cnt_en;
    logic        timer_irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rt_timer_ctrl #(.COUNT_LEN(64), .PRESC_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .cnt_value(cnt_value), .cnt_load(cnt_load), .cnt_data(cnt_data),
        .cnt_en(cnt_en), .timer_irq(timer_irq)
    );

    // Reference model state
    logic [63:0] m_cnt = '0;
    logic        m_run, m_irqen, m_lock, m_staged, m_load, m_irq, m_rdv, m_sv, m_ssel;
    logic [7:0]  m_presc, m_phase;
    logic [63:0] m_cmp, m_ldata;
    logic [31:0] m_lo, m_rdd, m_snap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_en();
        return m_run && !m_load && (m_phase == m_presc);
    endfunction

    task automatic m_reset();
        m_run = 0; m_irqen = 0; m_presc = 0; m_phase = 0; m_cmp = '1; m_lock = 0;
        m_staged = 0; m_lo = 0; m_load = 0; m_ldata = 0; m_irq = 0;
        m_rdv = 0; m_rdd = 0; m_snap = 0; m_sv = 0; m_ssel = 0;
    endtask

    // One clock edge worth of architectural effects, all from pre-edge state.
    task automatic model_edge();
        logic en_old;
        logic load_old;
        logic [63:0] ldata_old;
        if (rst) begin
            m_reset();
            return;
        end
        en_old    = m_en();
        load_old  = m_load;
        ldata_old = m_ldata;
        // read
        m_rdv = rd_en;
        if (rd_en) begin
            case (rd_addr)
                3'd0: begin m_rdd = m_cnt[31:0]; m_snap = m_cnt[63:32]; m_sv = 1; m_ssel = 0; end
                3'd2: begin m_rdd = m_cmp[31:0]; m_snap = m_cmp[63:32]; m_sv = 1; m_ssel = 1; end
                3'd1: begin m_rdd = (m_sv && !m_ssel) ? m_snap : m_cnt[63:32]; m_sv = 0; end
                3'd3: begin m_rdd = (m_sv && m_ssel) ? m_snap : m_cmp[63:32]; m_sv = 0; end
                3'd4: m_rdd = {16'b0, m_presc, 6'b0, m_irqen, m_run};
                default: m_rdd = 0;
            endcase
        end
        // interrupt
        m_irq = m_irqen && !m_lock && (m_cnt >= m_cmp);
        // prescaler position
        if (m_load || (wr_en && wr_addr == 3'd4 && wr_data[15:8] != m_presc))
            m_phase = 0;
        else if (m_run)
            m_phase = (m_phase == m_presc) ? 8'd0 : m_phase + 8'd1;
        // writes
        m_load = 0;
        if (wr_en) begin
            case (wr_addr)
                3'd0: begin m_staged = 1; m_lo = wr_data; end
                3'd1: begin
                    m_load = 1;
                    m_ldata = {wr_data, m_staged ? m_lo : m_cnt[31:0]};
                    m_staged = 0;
                end
                3'd2: begin m_cmp[31:0] = wr_data; m_lock = 1; end
                3'd3: begin m_cmp[63:32] = wr_data; m_lock = 0; end
                3'd4: begin m_run = wr_data[0]; m_irqen = wr_data[1]; m_presc = wr_data[15:8]; end
                default: ;
            endcase
        end
        // ideal counter
        if (load_old) m_cnt = ldata_old;
        else if (en_old) m_cnt = m_cnt + 64'd1;
    endtask

    task automatic check_all();
        chk("cnt_load", 64'(cnt_load), 64'(m_load));
        chk("cnt_data", cnt_data, m_ldata);
        chk("cnt_en", 64'(cnt_en), 64'(m_en()));
        chk("timer_irq", 64'(timer_irq), 64'(m_irq));
        chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
        if (m_rdv || rst) chk("rd_data", 64'(rd_data), 64'(m_rdd));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        cnt_value = m_cnt;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1; rd_addr = a;
        step();
        rd_en = 0;
    endtask

    int cnt;
    int t100;
    int tirq;

    initial begin
        m_reset();
        // Reset held through random CSR activity
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = $urandom;
            rd_en = 1'($urandom); rd_addr = 3'($urandom);
            step();
        end
        wr_en = 0; rd_en = 0;
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_irq", 64'(timer_irq), 64'd0);
        rst = 0;
        rd(3'd2);
        chk("rst_cmp_lo", 64'(rd_data), 64'hFFFF_FFFF);
        rd(3'd3);
        chk("rst_cmp_hi", 64'(rd_data), 64'hFFFF_FFFF);
        rd(3'd4);
        chk("rst_ctrl", 64'(rd_data), 64'd0);

        // Atomic MTIME load
        wr(3'd0, 32'h0000_0064);
        chk("ld_none_yet", 64'(cnt_load), 64'd0);
        wr(3'd1, 32'h0);
        chk("ld_pulse", 64'(cnt_load), 64'd1);
        chk("ld_data", cnt_data, 64'h64);
        chk("ld_no_en", 64'(cnt_en), 64'd0);
        step();
        chk("ld_single", 64'(cnt_load), 64'd0);

        // Prescaler
        wr(3'd4, 32'h0000_0301);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin step(); cnt += int'(cnt_en); end
        chk("presc3_count", 64'(cnt), 64'd3);
        wr(3'd4, 32'h0000_0001);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin step(); cnt += int'(cnt_en); end
        chk("presc0_count", 64'(cnt), 64'd8);
        wr(3'd4, 32'h0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin step(); cnt += int'(cnt_en); end
        chk("stopped_count", 64'(cnt), 64'd0);

        // Compare interrupt
        wr(3'd2, 32'd100);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd95);
        wr(3'd1, 32'd0);
        step();
        wr(3'd4, 32'h0000_0003);
        t100 = -1; tirq = -1;
        for (int i = 0; i < 30 && tirq < 0; i++) begin
            step();
            if (cnt_value == 64'd100) t100 = i;
            if (timer_irq && tirq < 0) tirq = i;
        end
        chk("irq_seen", 64'(tirq >= 0), 64'd1);
        chk("irq_lag", 64'(tirq - t100), 64'd1);
        wr(3'd2, 32'd100);
        step();
        chk("irq_locked", 64'(timer_irq), 64'd0);
        idle(3);
        chk("irq_still_locked", 64'(timer_irq), 64'd0);
        wr(3'd3, 32'd0);
        step();
        chk("irq_unlocked", 64'(timer_irq), 64'd1);
        wr(3'd4, 32'h0);

        // HI snapshot across a carry
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'h1);
        step();
        rd(3'd0);
        chk("snap_lo", 64'(rd_data), 64'hFFFF_FFFF);
        wr(3'd4, 32'h1);
        idle(3);
        rd(3'd1);
        chk("snap_hi", 64'(rd_data), 64'h1);
        wr(3'd4, 32'h0);
        rd(3'd1);
        chk("live_hi", 64'(rd_data), 64'h2);

        // Reset between LO and HI writes
        wr(3'd0, 32'hAAAA_5555);
        rst = 1;
        step();
        rst = 0;
        wr(3'd1, 32'd5);
        chk("rst_mid_load", 64'(cnt_load), 64'd1);
        chk("rst_mid_data", cnt_data, {32'd5, m_cnt[31:0]});
        step();

        // Back-to-back HI writes
        wr(3'd1, 32'd7);
        wr(3'd1, 32'd8);
        chk("b2b_second", 64'(cnt_load), 64'd1);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom);
            case (wr_addr)
                3'd0: wr_data = $urandom_range(0, 300);
                3'd1: wr_data = 32'($urandom_range(0, 7) == 0);
                3'd2: wr_data = $urandom_range(0, 400);
                3'd3: wr_data = 32'($urandom_range(0, 7) == 0);
                3'd4: wr_data = ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
                default: wr_data = $urandom;
            endcase
            rd_en   = 1'($urandom);
            rd_addr = 3'($urandom);
            step();
        end
        wr_en = 0; rd_en = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rt_timer_ctrl.md
# rt_timer_ctrl

Controller that sequences the 64-bit real-time counter from the core's 32-bit CSR bus. It splits 32-bit accesses into atomic 64-bit counter loads, generates the counter's increment enable through a programmable prescaler, holds the 64-bit compare register and raises the machine timer interrupt. It sits between the CSR file and the real-time counter: it drives the counter's load and enable inputs and observes its output.

## Interface
- COUNT_LEN, 64, counter width; fixed at 64 for the 2×32-bit register split.
- PRESC_W, 8, prescaler divisor width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  CSR write strobe, one access per cycle.
- wr_addr  in  3  write register select.
- wr_data  in  32  write data.
- rd_en  in  1  CSR read strobe.
- rd_addr  in  3  read register select.
- rd_data  out  32  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- cnt_value  in  64  current counter output.
- cnt_load  out  1  one-cycle load pulse to the counter.
- cnt_data  out  64  load value; valid while cnt_load=1.
- cnt_en  out  1  counter increment enable.
- timer_irq  out  1  level timer interrupt.

## Operation
- Register map: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 run, bit1 irq_en, bits[15:8] presc). Addresses 5–7: writes ignored, reads return 0.
- MTIME write FSM, states IDLE, LO_STAGED, LOAD:
  - IDLE + write LO -> LO_STAGED, lo_stage=wr_data.
  - LO_STAGED + write LO -> LO_STAGED, lo_stage overwritten.
  - LO_STAGED + write HI -> LOAD, cnt_data={wr_data, lo_stage}.
  - IDLE + write HI -> LOAD, cnt_data={wr_data, cnt_value[31:0]}.
  - LOAD -> IDLE unconditionally; cnt_load=1 only in LOAD.
  - Writes to other addresses do not change the FSM state.
- Prescaler: presc_cnt counts 0..presc. When run=1 and presc_cnt==presc, cnt_en=1 for that cycle and presc_cnt returns to 0. presc=0 gives cnt_en=1 every cycle. With run=0, cnt_en=0 and presc_cnt holds.
- In LOAD: cnt_en is forced to 0 and presc_cnt clears to 0.
- A CTRL write that changes presc clears presc_cnt.
- MTIMECMP: a LO write updates cmp[31:0] and sets cmp_lock. A HI write updates cmp[63:32] and clears cmp_lock.
- Interrupt: timer_irq <= irq_en & ~cmp_lock & (cnt_value >= cmp), compared as 64-bit unsigned. It stays high until the compare condition or irq_en clears.
- Reads:
  - A LO read (MTIME_LO or MTIMECMP_LO) returns the low word and captures the matching high word into hi_snap, setting snap_valid.
  - The next HI read of the same register returns hi_snap and clears snap_valid.
  - A HI read without a valid snapshot returns the live high word.
  - A read of the other register pair clears snap_valid.
  - A CTRL read returns {16'b0, presc, 6'b0, irq_en, run}.
- Simultaneous rd_en and wr_en: both are serviced, and the read returns the pre-write value.

## Timing
- Reset values: rd_data=0, rd_valid=0, cnt_load=0, cnt_data=0, cnt_en=0, timer_irq=0, CTRL=0, cmp=all ones, cmp_lock=0, snap_valid=0, FSM=IDLE, presc_cnt=0.
- Reset mid-sequence discards lo_stage and any pending load; no cnt_load is issued.
- Read latency is 1: rd_en sampled at edge N gives rd_data and rd_valid during cycle N+1.
- MTIME HI write sampled at edge N gives cnt_load=1 during cycle N+1. The counter shows the new value from edge N+2.
- Back-to-back HI writes: the second is sampled while in LOAD, is treated as an IDLE HI write, and produces a second cnt_load pulse one cycle after the first.
- timer_irq lags cnt_value by 1 cycle. A write to cmp or CTRL affects timer_irq 2 cycles after the write is sampled.
- Counter wrap-around (all ones -> 0) is the counter's behaviour; compare semantics are unchanged, so timer_irq drops after the wrap when cmp>0.

## Test plan
- Reset with random wr/rd activity -> all outputs at their reset values; cmp=FFFF_FFFF_FFFF_FFFF; no timer_irq.
- Write MTIME_LO=0x0000_0064 then MTIME_HI=0 -> a single cnt_load pulse with cnt_data=0x64, one cycle after the HI write; no cnt_en in that cycle.
- CTRL run=1, presc=3 -> cnt_en pulses every 4th cycle. Setting presc=0 -> cnt_en every cycle. Setting run=0 -> cnt_en stays 0.
- cmp=100, irq_en=1, counter counting from 95 -> timer_irq rises the cycle after cnt_value=100. Writing MTIMECMP_LO drops timer_irq until MTIMECMP_HI is written.
- cnt_value=0x0000_0001_FFFF_FFFF, read LO, counter then carries, read HI -> reads return 0xFFFF_FFFF then 0x0000_0001 (snapshot), not 2.
- Assert rst between the LO and HI writes, then write HI=5 -> cnt_data={5, cnt_value[31:0]}; the staged LO value is not used.
